// File: rtl/round_robin_requester.sv
// rtl/round_robin_requester.sv - FIFO-backed arbiter client with bounded burst and forced yield
module round_robin_requester #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       request,
  input  logic                       grant,
  output logic                       bus_valid,
  output logic [WIDTH-1:0]           bus_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       grant_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(MAX_BURST+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             yield_q;
  logic             grant_error_q;
  logic             push, pop, burst_done;

  assign level       = level_q;
  assign in_ready    = (level_q != LVL_W'(DEPTH));
  assign request     = (level_q != '0) & ~yield_q;
  assign bus_valid   = request & grant;
  assign bus_data    = mem[rd_ptr];
  assign grant_error = grant_error_q;

  assign push       = in_valid & in_ready;
  assign pop        = bus_valid;
  assign burst_done = pop & (burst_cnt == CNT_W'(MAX_BURST-1));

  // Storage needs no reset: contents are only observed through level-qualified outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Any cycle without a transfer ends the burst; reaching the limit forces one idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt     <= '0;
      yield_q       <= 1'b0;
      grant_error_q <= 1'b0;
    end else begin
      yield_q <= burst_done;
      if (!pop || burst_done) begin
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      if (grant && !request) begin
        grant_error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_round_robin_requester.sv
// tb/tb_round_robin_requester.sv - scoreboard bench for round_robin_requester
module tb_round_robin_requester;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 2;
  localparam int LVL_W     = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             request;
  logic             grant = 1'b0;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic [LVL_W-1:0] level;
  logic             grant_error;

  int checks = 0;
  int errors = 0;

  // Reference state: contents as a queue, plus run length of back-to-back transfers.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb[$];
  int               m_run = 0;
  bit               m_yield = 0;
  bit               m_gerr = 0;

  round_robin_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .request(request), .grant(grant), .bus_valid(bus_valid), .bus_data(bus_data),
    .level(level), .grant_error(grant_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every bus transfer must present the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && bus_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected actual=%0h expected=none t=%0t", bus_data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = sb.pop_front();
        if (bus_data !== e) begin
          errors++;
          $display("FAIL bus_data actual=%0h expected=%0h t=%0t", bus_data, e, $time);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit g);
    bit exp_req, exp_bv, exp_ir;
    in_valid = v;
    in_data  = d;
    grant    = g;
    @(negedge clk);
    exp_req = (mq.size() != 0) && !m_yield;
    exp_bv  = exp_req && g;
    exp_ir  = (mq.size() != DEPTH);
    chk("request", int'(request), int'(exp_req));
    chk("bus_valid", int'(bus_valid), int'(exp_bv));
    chk("in_ready", int'(in_ready), int'(exp_ir));
    chk("level", int'(level), mq.size());
    chk("grant_error", int'(grant_error), int'(m_gerr));
    m_yield = 0;
    if (exp_bv) begin
      void'(mq.pop_front());
      m_run++;
      if (m_run == MAX_BURST) begin
        m_run = 0;
        m_yield = 1;
      end
    end else begin
      m_run = 0;
    end
    if (v && exp_ir) begin
      mq.push_back(d);
      sb.push_back(d);
    end
    if (g && !exp_req) m_gerr = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    grant = 1'b0;
    mq.delete();
    sb.delete();
    m_run = 0;
    m_yield = 0;
    m_gerr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Empty after reset, then grants with nothing requested
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (3) step(0, '0, 1);
    chk("gerr_sticky", int'(grant_error), 1);

    // Three words, then continuous grant: burst of 2, yield, last word
    do_reset();
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    step(1, 8'hA3, 0);
    repeat (6) step(0, '0, 1);
    chk("drain_level", int'(level), 0);

    // Overfill, then pop and push across the pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'hB0 + 8'(i), 0);
    chk("full_level", int'(level), DEPTH);
    step(0, '0, 1);
    step(1, 8'hC0, 0);
    step(1, 8'hC1, 0);
    repeat (8) step(0, '0, 1);

    // Simultaneous push and pop at level 2
    do_reset();
    step(1, 8'h11, 0);
    step(1, 8'h12, 0);
    step(1, 8'h13, 1);
    chk("pushpop_level", int'(level), 2);
    step(1, 8'h14, 0);
    repeat (6) step(0, '0, 1);

    // Alternating grant keeps the burst counter below the limit
    do_reset();
    for (int i = 0; i < 12; i++) step((i < 8), 8'h60 + 8'(i), (i % 2) == 0);
    repeat (6) step(0, '0, 1);

    // Asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h70 + 8'(i), 0);
    step(0, '0, 1);
    grant = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_request", int'(request), 0);
    chk("arst_bus_valid", int'(bus_valid), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    do_reset();
    step(1, 8'h5C, 0);
    step(0, '0, 1);
    chk("post_rst_empty", sb.size(), 0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < ((i / 100) % 2 ? 85 : 45)));
    end
    for (int i = 0; i < 3 * DEPTH; i++) step(0, '0, 1);
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_requester.md
Name: round_robin_requester

Overview:
- Client-side front end for the 2-request round-robin arbiter. One instance sits on each arbiter request line.
- Buffers outgoing words from a local producer in a small FIFO and raises `request` while it has data.
- Pops one word onto the shared bus on every cycle it is granted.
- Voluntarily yields after a bounded burst so the other client is never starved, even if the arbiter grant is held.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_BURST, 2, max consecutive granted transfers before a forced 1-cycle yield; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  producer word.
- in_ready  output  1  FIFO can accept a word this cycle.
- request  output  1  request line to the arbiter (one bit of its requests vector).
- grant  input  1  matching grant bit from the arbiter.
- bus_valid  output  1  word on bus_data is transferred this cycle.
- bus_data  output  WIDTH  head-of-FIFO word.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- grant_error  output  1  sticky: a grant arrived while request was low.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, level=0, burst counter=0, yield flag=0, grant_error=0.
  - Outputs during reset: request=0, bus_valid=0, in_ready=1; bus_data don't-care.
- Push: in_valid & in_ready at a rising edge writes in_data at the write pointer.
  - in_ready = (level != DEPTH); no pass-through when full.
- request = (level != 0) & ~yield. Combinational from state only; never depends on grant (no loop through the arbiter).
- Transfer: bus_valid = request & grant, combinational.
  - bus_data = FIFO head at all times; a defined value when empty is not required.
  - On the edge where bus_valid=1, the head is popped. Latency from push to earliest transfer is 1 cycle.
- Simultaneous push and pop: level unchanged, both pointers advance. Allowed at any level < DEPTH; at DEPTH only the pop happens.
- Pointers wrap modulo DEPTH. Full/empty are derived from level, never from pointer equality alone.
- Burst counter:
  - Increments on each transfer.
  - Clears on any cycle with request=1 & grant=0, and whenever request=0.
  - When a transfer makes the count reach MAX_BURST: counter clears and yield=1 for exactly the next cycle (request forced 0), then yield returns to 0.
- Yield is forced even if the other client is idle, so throughput with one active client is MAX_BURST/(MAX_BURST+1).
- Grant while request=0 (empty, yielding, or reset released): no pop, no bus_valid, grant_error set. Cleared only by rst.
- FIFO becoming empty mid-burst: request drops the cycle after the last pop; counter clears.
- Reset mid-burst or with data buffered: all contents discarded immediately, no bus_valid after rst asserts.

Test Plan:
- Reset, DEPTH=4: after rst release, level=0, request=0, in_ready=1, grant_error=0. Hold grant=1 for 3 cycles -> bus_valid stays 0, grant_error=1.
- Push 0xA1, 0xA2, 0xA3 with grant=0 -> request=1 from the cycle after the first push, level=3. Then grant=1 continuously -> transfers 0xA1, 0xA2 on consecutive cycles, request=0 for 1 cycle, then 0xA3 transferred, then request=0, level=0.
- Push 5 words back-to-back with grant=0 -> in_ready falls after the 4th, 5th not accepted, level=4. One grant cycle then push -> level stays 4, word order preserved across pointer wrap.
- Steady state, level=2: push and transfer on the same cycle -> level stays 2, pushed word emerges in FIFO order.
- Alternating grant 1,0,1,0 with 6 words queued -> burst counter clears on every ungranted cycle, so no yield occurs. All 6 words out in order within 12 cycles.
- Assert rst mid-burst with level=3 -> request, bus_valid and level go 0 asynchronously (before the next clock edge). After release, a new push 0x5C is transferred first, with no stale data.
